// File: rtl/rc4_key_search_if.sv
// Bus between the RC4 key-search controller, its DM read port and the pipeline stages.
// master: the controller; slave: the pipeline and the DM memory.
interface rc4_key_search_if;
  logic        start;
  logic [7:0]  dm_addr;
  logic [7:0]  dm_q;
  logic [23:0] key;
  logic        restart;
  logic        busy;
  logic        found;
  logic        fail;
  logic [2:0]  state_dbg;

  modport master (
    input  start, dm_q,
    output dm_addr, key, restart, busy, found, fail, state_dbg
  );

  modport slave (
    output start, dm_q,
    input  dm_addr, key, restart, busy, found, fail, state_dbg
  );
endinterface

// File: rtl/rc4_key_search.sv
// Scans each decrypted DM message for lowercase letters and spaces; holds the key on a hit,
// otherwise advances the key and pulses restart until KEY_MAX has been rejected.
module rc4_key_search #(
    parameter int          MSG_LEN = 32,
    parameter logic [23:0] KEY_MAX = 24'h3FFFFF
) (
    input  logic             clk,
    input  logic             reset,
    rc4_key_search_if.master bus
);

    // Pulse protocol: start and restart are single-cycle strobes with no backpressure.
    // start counts only when the FSM is in IDLE; it is never queued.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_NEXT  = 3'd4,
        S_FOUND = 3'd5,
        S_FAIL  = 3'd6
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(MSG_LEN - 1);

    state_t      state, state_n;
    logic [7:0]  idx, idx_n;
    logic [23:0] key_q, key_n;
    logic        found_q, fail_q;
    logic        byte_ok;

    assign byte_ok = ((bus.dm_q >= 8'h61) && (bus.dm_q <= 8'h7A)) || (bus.dm_q == 8'h20);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            idx     <= 8'd0;
            key_q   <= 24'd0;
            found_q <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            key_q   <= key_n;
            found_q <= found_q | (state == S_FOUND);
            fail_q  <= fail_q | (state == S_FAIL);
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        key_n   = key_q;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    idx_n   = 8'd0;
                    state_n = S_RD;
                end
            end
            S_RD:   state_n = S_WAIT;
            S_WAIT: state_n = S_CHECK;
            S_CHECK: begin
                // dm_q here belongs to idx: the RAM has had two edges since idx changed.
                if (byte_ok) begin
                    if (idx == LAST_IDX) begin
                        state_n = S_FOUND;
                    end else begin
                        idx_n   = idx + 8'd1;
                        state_n = S_RD;
                    end
                end else if (key_q == KEY_MAX) begin
                    state_n = S_FAIL;
                end else begin
                    key_n   = key_q + 24'd1;
                    state_n = S_NEXT;
                end
            end
            S_NEXT:  state_n = S_IDLE;
            S_FOUND: state_n = S_FOUND;
            S_FAIL:  state_n = S_FAIL;
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.dm_addr   = idx;
    assign bus.key       = key_q;
    assign bus.restart   = (state == S_NEXT);
    assign bus.busy      = (state == S_RD) || (state == S_WAIT) ||
                           (state == S_CHECK) || (state == S_NEXT);
    assign bus.found     = found_q;
    assign bus.fail      = fail_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_rc4_key_search.sv
// Directed bench for rc4_key_search: a vector table of DM contents plus hand sequences
// for start-during-restart, key exhaustion and reset mid-check.
module tb_rc4_key_search;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_FAIL = 3'd6;

  logic clk;
  logic rst_a;
  logic rst_b;

  rc4_key_search_if bus_a ();
  rc4_key_search_if bus_b ();

  rc4_key_search #(.MSG_LEN(32), .KEY_MAX(24'h3FFFFF)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a.master)
  );

  rc4_key_search #(.MSG_LEN(32), .KEY_MAX(24'd3)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b.master)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // two-stage synchronous DM model for dut_a; dut_b always sees an invalid byte
  logic [7:0] mem [256];
  logic [7:0] ram_r1;
  always @(posedge clk) begin
    ram_r1     <= mem[bus_a.dm_addr];
    bus_a.dm_q <= ram_r1;
  end
  assign bus_b.dm_q = 8'h00;

  // scoreboard
  int assertions = 0;
  int failures   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  typedef struct {
    logic [7:0]  fill;
    int          pos;
    logic [7:0]  val;
    logic        exp_found;
    int          exp_edge;
    logic [23:0] exp_key;
    int          exp_naddr;
  } vec_t;

  vec_t vecs[9];

  // driver tasks
  task automatic do_reset_a();
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic fill_mem(input logic [7:0] fill, input int pos, input logic [7:0] val);
    for (int i = 0; i < 256; i++) mem[i] = fill;
    mem[pos] = val;
  endtask

  // Pulse start (sampled at edge 0), then watch dut_a until found rises or the cycle after
  // a restart pulse. Edges are counted from the start-sampling edge.
  task automatic run_check(output int found_edge, output int restart_edge, output int restart_cnt,
                           output int naddr, output int bad_addr, output logic busy_last);
    found_edge   = -1;
    restart_edge = -1;
    restart_cnt  = 0;
    naddr        = 0;
    bad_addr     = 0;
    busy_last    = 1'b1;
    exp_q.delete();
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (bus_a.state_dbg == ST_RD) begin
        exp_q.push_back(32'(naddr));
        if (32'(bus_a.dm_addr) != exp_q.pop_front()) bad_addr++;
        naddr++;
      end
      if (bus_a.restart) begin
        restart_cnt++;
        if (restart_edge < 0) restart_edge = n;
      end
      if (bus_a.found && found_edge < 0) found_edge = n;
      busy_last = bus_a.busy;
      if (found_edge >= 0) break;
      if (restart_edge >= 0 && n == restart_edge + 1) break;
    end
  endtask

  initial begin
    int fe, re, rc, na, ba;
    logic bl;
    string nm;

    vecs[0] = '{8'h61, 0,  8'h61, 1'b1, 97, 24'd0, 32};
    vecs[1] = '{8'h61, 0,  8'h41, 1'b0, 3,  24'd1, 1};
    vecs[2] = '{8'h20, 31, 8'h7B, 1'b0, 96, 24'd1, 32};
    vecs[3] = '{8'h61, 5,  8'h20, 1'b1, 97, 24'd0, 32};
    vecs[4] = '{8'h61, 5,  8'h7A, 1'b1, 97, 24'd0, 32};
    vecs[5] = '{8'h61, 5,  8'h1F, 1'b0, 18, 24'd1, 6};
    vecs[6] = '{8'h61, 5,  8'h60, 1'b0, 18, 24'd1, 6};
    vecs[7] = '{8'h61, 5,  8'h7B, 1'b0, 18, 24'd1, 6};
    vecs[8] = '{8'h20, 31, 8'h7A, 1'b1, 97, 24'd0, 32};

    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;

    check("reset_key",     32'(bus_a.key),     32'd0);
    check("reset_dm_addr", 32'(bus_a.dm_addr), 32'd0);
    check("reset_restart", 32'(bus_a.restart), 32'd0);
    check("reset_busy",    32'(bus_a.busy),    32'd0);
    check("reset_found",   32'(bus_a.found),   32'd0);
    check("reset_fail",    32'(bus_a.fail),    32'd0);
    check("reset_state",   32'(bus_a.state_dbg), 32'(ST_IDLE));

    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // vector table
    for (int v = 0; v < 9; v++) begin
      do_reset_a();
      fill_mem(vecs[v].fill, vecs[v].pos, vecs[v].val);
      run_check(fe, re, rc, na, ba, bl);
      nm = $sformatf("v%0d", v);
      if (vecs[v].exp_found) begin
        check({nm, "_found_edge"}, 32'(fe), 32'(vecs[v].exp_edge));
        check({nm, "_restart_cnt"}, 32'(rc), 32'd0);
      end else begin
        check({nm, "_restart_edge"}, 32'(re), 32'(vecs[v].exp_edge));
        check({nm, "_restart_cnt"}, 32'(rc), 32'd1);
        check({nm, "_found"}, 32'(bus_a.found), 32'd0);
      end
      check({nm, "_key"}, 32'(bus_a.key), 32'(vecs[v].exp_key));
      check({nm, "_naddr"}, 32'(na), 32'(vecs[v].exp_naddr));
      check({nm, "_addr_seq_errs"}, 32'(ba), 32'd0);
      check({nm, "_busy_after"}, 32'(bl), 32'd0);
      check({nm, "_fail"}, 32'(bus_a.fail), 32'd0);
    end

    // start held during NEXT is ignored; start in the following IDLE cycle is accepted
    do_reset_a();
    fill_mem(8'h61, 0, 8'h41);
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("seq_restart_high", 32'(bus_a.restart), 32'd1);
    check("seq_key1", 32'(bus_a.key), 32'd1);
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1;
    check("seq_start_in_next_ignored", 32'(bus_a.state_dbg), 32'(ST_IDLE));
    check("seq_busy_idle", 32'(bus_a.busy), 32'd0);
    check("seq_restart_low", 32'(bus_a.restart), 32'd0);
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    check("seq_start_in_idle_taken", 32'(bus_a.state_dbg), 32'(ST_RD));
    repeat (3) @(posedge clk);
    #1;
    check("seq_restart2", 32'(bus_a.restart), 32'd1);
    check("seq_key2", 32'(bus_a.key), 32'd2);

    // reset mid-check returns everything to reset values at once
    @(posedge clk);
    #1;
    fill_mem(8'h61, 0, 8'h61);
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("rst_mid_busy_before", 32'(bus_a.busy), 32'd1);
    rst_a = 1'b1;
    #1;
    check("rst_mid_key", 32'(bus_a.key), 32'd0);
    check("rst_mid_dm_addr", 32'(bus_a.dm_addr), 32'd0);
    check("rst_mid_busy", 32'(bus_a.busy), 32'd0);
    check("rst_mid_restart", 32'(bus_a.restart), 32'd0);
    check("rst_mid_state", 32'(bus_a.state_dbg), 32'(ST_IDLE));
    @(negedge clk);
    rst_a = 1'b0;
    run_check(fe, re, rc, na, ba, bl);
    check("rst_mid_found_edge", 32'(fe), 32'd97);
    check("rst_mid_restart_cnt", 32'(rc), 32'd0);
    check("rst_mid_key_after", 32'(bus_a.key), 32'd0);

    // key exhaustion on the KEY_MAX=3 instance
    for (int r = 0; r < 4; r++) begin
      int seen_restart;
      seen_restart = 0;
      @(negedge clk);
      bus_b.start = 1'b1;
      @(posedge clk);
      #1;
      bus_b.start = 1'b0;
      for (int n = 1; n <= 6; n++) begin
        @(posedge clk);
        #1;
        if (bus_b.restart) seen_restart++;
      end
      if (r < 3) begin
        check($sformatf("kmax_r%0d_restart", r), 32'(seen_restart), 32'd1);
        check($sformatf("kmax_r%0d_key", r), 32'(bus_b.key), 32'(r + 1));
        check($sformatf("kmax_r%0d_fail", r), 32'(bus_b.fail), 32'd0);
      end else begin
        check("kmax_last_restart", 32'(seen_restart), 32'd0);
        check("kmax_last_key", 32'(bus_b.key), 32'd3);
        check("kmax_last_fail", 32'(bus_b.fail), 32'd1);
      end
    end
    @(negedge clk);
    bus_b.start = 1'b1;
    @(posedge clk);
    #1;
    bus_b.start = 1'b0;
    check("kmax_start_ignored_busy", 32'(bus_b.busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("kmax_hold_state", 32'(bus_b.state_dbg), 32'(ST_FAIL));
    check("kmax_hold_key", 32'(bus_b.key), 32'd3);
    check("kmax_hold_fail", 32'(bus_b.fail), 32'd1);
    check("kmax_hold_found", 32'(bus_b.found), 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/rc4_key_search.md
# rc4_key_search

Downstream controller of the RC4 decrypt pipeline (KSA, swap loop, PRGA). After each decryption pass it reads the decrypted message out of DM memory and checks that every byte is a lowercase letter or a space. If the message is plausible, it stops and holds the key. Otherwise it advances the 24-bit key and pulses a restart so the pipeline re-runs with that key. It exhausts the key range and then reports failure.

## Interface
Parameters:
- MSG_LEN, 32, number of decrypted bytes checked (DM addresses 0..MSG_LEN-1); 1..256
- KEY_MAX, 24'h3FFFFF, last key value tried; the search covers 0..KEY_MAX

Ports:
- clk  in  1  single system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse from the PRGA stage (its done flag): DM holds a complete message
- dm_addr  out  8  DM read address
- dm_q  in  8  DM read data; synchronous RAM, valid 2 edges after dm_addr changes
- key  out  24  current key driven to the KSA stage
- restart  out  1  one-cycle pulse: the key was advanced and the pipeline must re-run
- busy  out  1  high while a check is in progress
- found  out  1  sticky; the message under `key` passed
- fail  out  1  sticky; KEY_MAX was rejected and the search is exhausted

## Operation
- Reset values:
  - outputs: key=0, dm_addr=0, restart=0, busy=0, found=0, fail=0
  - internal: state=IDLE, idx=0
- dm_addr is driven directly from the registered idx.
- Valid byte: 8'h61..8'h7A, or 8'h20. Every other value is invalid.
- State machine:
  - IDLE:
    - start=1 → idx←0, go to RD.
    - Otherwise stay.
  - RD: dm_addr=idx → WAIT.
  - WAIT: RAM latency → CHECK.
  - CHECK (dm_q is for idx):
    - Valid and idx=MSG_LEN-1 → FOUND.
    - Valid, not last → idx←idx+1, go to RD.
    - Invalid and key=KEY_MAX → FAIL.
    - Invalid, otherwise → key←key+1, go to NEXT.
  - NEXT: restart=1 for exactly this cycle → IDLE.
  - FOUND: found=1 → stays until reset.
  - FAIL: fail=1 → stays until reset.
- busy=1 in RD, WAIT, CHECK and NEXT; 0 elsewhere.
- Where start is ignored:
  - In any state other than IDLE; it is not queued.
  - In FOUND or FAIL.
- key changes only on the CHECK→NEXT transition, so it stays stable throughout the pipeline re-run.
- The key never wraps past KEY_MAX.
- idx is 8 bits. It never exceeds MSG_LEN-1.

## Timing
- Per byte: 3 cycles (RD, WAIT, CHECK).
- Full accept path: start sampled at edge 0 → found rises at edge 3·MSG_LEN+1 (97 for MSG_LEN=32).
- Reject at byte k: restart is high in the cycle after edge 3(k+1), lasts 1 cycle, and the FSM is back in IDLE at the following edge.
- key updates on the same edge that restart rises.
- start in the same cycle as restart: ignored (the FSM is in NEXT, not IDLE).
- start in the first IDLE cycle after NEXT: accepted.
- Reset asserted mid-check: all registers return to their reset values asynchronously; key returns to 0; no restart pulse is emitted.
- found/fail are registered outputs and never glitch.

## Test plan
- DM preloaded with 32 bytes 8'h61; reset; start pulse → found=1 at edge 97; key=0; restart never pulses; busy falls when found rises.
- DM[0]=8'h41; start → restart pulses once at cycle 4; key=1; busy=0 next cycle; a second start re-checks and rejects again, giving key=2.
- DM[31]=8'h7B, all other bytes 8'h20 → rejected after 96 cycles; key=1; the address sequence observed on dm_addr is 0..31.
- Boundary bytes: 8'h20, 8'h61 and 8'h7A all accepted; 8'h1F, 8'h60 and 8'h7B each cause a reject.
- KEY_MAX=3, DM always invalid, start repeated after each restart → key steps 0,1,2,3; the fourth reject sets fail=1 with key=3; further starts are ignored.
- Reset asserted at edge 40 of a valid check → outputs return immediately to reset values; a fresh start then yields found at edge 97.
